// File: rtl/grf_read_hazard.sv
// Decode-side general register file with write-back bypass and a two-entry
// shadow pipeline (E, M) that raises Stall whenever an operand's Tuse precedes its producer's Tnew.
module grf_read_hazard #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        D_RA1,
    input  logic [4:0]        D_RA2,
    input  logic [1:0]        D_Tuse1,
    input  logic [1:0]        D_Tuse2,
    input  logic [4:0]        D_WA,
    input  logic [1:0]        D_Tnew,
    input  logic              W_WE,
    input  logic [4:0]        W_WA,
    input  logic [DATA_W-1:0] W_WD,
    output logic [DATA_W-1:0] D_RD1,
    output logic [DATA_W-1:0] D_RD2,
    output logic              Stall
);

    localparam logic [1:0] TUSE_NONE = 2'd3;

    logic [DATA_W-1:0] regs_q [32];
    logic [DATA_W-1:0] regs_d [32];

    logic [4:0] e_wa_q, e_wa_d;
    logic [1:0] e_tnew_q, e_tnew_d;
    logic [4:0] m_wa_q, m_wa_d;
    logic [1:0] m_tnew_q, m_tnew_d;

    logic stall_1, stall_2;
    logic w_hit_1, w_hit_2;

    // The youngest matching producer (E) shadows any older one in M.
    function automatic logic src_stall(
        input logic [4:0] ra,
        input logic [1:0] tuse,
        input logic [4:0] e_wa,
        input logic [1:0] e_tnew,
        input logic [4:0] m_wa,
        input logic [1:0] m_tnew
    );
        logic hit;
        hit = 1'b0;
        if (ra != 5'd0 && tuse != TUSE_NONE) begin
            if (e_wa == ra) begin
                hit = (e_tnew > tuse);
            end else if (m_wa == ra) begin
                hit = (m_tnew > tuse);
            end
        end
        return hit;
    endfunction

    // Register array write path.
    always_comb begin
        regs_d = regs_q;
        if (W_WE && W_WA != 5'd0) begin
            regs_d[W_WA] = W_WD;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read ports: $0 first, then the write-back bypass, then the array.
    always_comb begin
        w_hit_1 = W_WE && (W_WA == D_RA1);
        w_hit_2 = W_WE && (W_WA == D_RA2);

        if (D_RA1 == 5'd0) begin
            D_RD1 = '0;
        end else if (w_hit_1) begin
            D_RD1 = W_WD;
        end else begin
            D_RD1 = regs_q[D_RA1];
        end

        if (D_RA2 == 5'd0) begin
            D_RD2 = '0;
        end else if (w_hit_2) begin
            D_RD2 = W_WD;
        end else begin
            D_RD2 = regs_q[D_RA2];
        end
    end

    always_comb begin
        stall_1 = src_stall(D_RA1, D_Tuse1, e_wa_q, e_tnew_q, m_wa_q, m_tnew_q);
        stall_2 = src_stall(D_RA2, D_Tuse2, e_wa_q, e_tnew_q, m_wa_q, m_tnew_q);
        Stall   = stall_1 | stall_2;
    end

    // Shadow pipeline advance: a stall injects a bubble into E while M keeps draining.
    always_comb begin
        e_wa_d   = D_WA;
        e_tnew_d = D_Tnew;
        if (Stall) begin
            e_wa_d   = 5'd0;
            e_tnew_d = 2'd0;
        end
        m_wa_d   = e_wa_q;
        m_tnew_d = (e_tnew_q == 2'd0) ? 2'd0 : e_tnew_q - 2'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_wa_q   <= 5'd0;
            e_tnew_q <= 2'd0;
            m_wa_q   <= 5'd0;
            m_tnew_q <= 2'd0;
        end else begin
            e_wa_q   <= e_wa_d;
            e_tnew_q <= e_tnew_d;
            m_wa_q   <= m_wa_d;
            m_tnew_q <= m_tnew_d;
        end
    end

endmodule
